// File: rtl/if_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_if : IF -> ID prefetch queue handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface if_fetch_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                      flush;
  logic                      push_valid;
  logic [PC_W-1:0]           push_pc_plus4;
  logic [INSTR_W-1:0]        push_instr;
  logic                      push_ready;
  logic                      pop_ready;
  logic                      pop_valid;
  logic [PC_W+INSTR_W-1:0]   IF_ID;
  logic [AW:0]               count;

  modport master (
    output flush, push_valid, push_pc_plus4, push_instr, pop_ready,
    input  push_ready, pop_valid, IF_ID, count
  );

  modport slave (
    input  flush, push_valid, push_pc_plus4, push_instr, pop_ready,
    output push_ready, pop_valid, IF_ID, count
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue : DEPTH-entry IF->ID prefetch FIFO, one-cycle flush, NOP when empty
// Optional macro IF_FETCH_QUEUE_BYPASS_EN : empty-queue zero-latency bypass. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_fetch_queue #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  wire logic          clk,
  input  wire logic          reset_b,
  if_fetch_queue_if.slave    bus
);
  localparam int            AW     = $clog2(DEPTH);
  localparam int            W      = PC_W + INSTR_W;
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_head_valid;
  logic          w_bypass;
  logic          w_push;
  logic          w_store;
  logic          w_adv_rd;
  logic [W-1:0]  w_word;

  assign w_word       = {bus.push_pc_plus4, bus.push_instr};
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_FULL);
  assign w_head_valid = !w_empty && !bus.flush;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && bus.push_valid && !bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // push_ready deliberately ignores pop_ready: a full queue never chains pop into push
  assign bus.push_ready = !w_full && !bus.flush;
  assign bus.pop_valid  = w_head_valid || w_bypass;
  assign bus.count      = r_count;

  always_comb begin
    bus.IF_ID = '0;
    if (w_head_valid) begin
      bus.IF_ID = r_mem[r_rd_ptr];
    end else if (w_bypass) begin
      bus.IF_ID = w_word;
    end
  end

  assign w_push   = bus.push_valid && bus.push_ready;
  assign w_adv_rd = w_head_valid && bus.pop_ready;
  // A bypassed word taken by ID in the same cycle never occupies a slot
  assign w_store  = w_push && !(w_bypass && bus.pop_ready);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_adv_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_store && !w_adv_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_store && w_adv_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

`ifndef SYNTHESIS
  // An underflow wraps the unsigned count above C_FULL, so one bound covers both
  a_count_range: assert property (@(posedge clk) disable iff (!reset_b) r_count <= C_FULL);
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue : directed scoreboard bench for if_fetch_queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_queue;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset_b;
  int   n_vec;
  int   n_err;
  logic [63:0] sb[$];

  if_fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  if_fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle (called at posedge+1), check at negedge, update scoreboard.
  task automatic step(input logic fl, input logic pv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic pr);
    int          n;
    logic        byp, e_pr, e_pv;
    logic [63:0] e_data;
    bus.flush         = fl;
    bus.push_valid    = pv;
    bus.push_pc_plus4 = pc;
    bus.push_instr    = ins;
    bus.pop_ready     = pr;
    @(negedge clk);
    n      = sb.size();
    byp    = BYP && (n == 0) && pv && !fl;
    e_pr   = (n != DEPTH) && !fl;
    e_pv   = ((n != 0) && !fl) || byp;
    e_data = ((n != 0) && !fl) ? sb[0] : (byp ? {pc, ins} : 64'h0);
    chk("push_ready", {63'h0, bus.push_ready}, {63'h0, e_pr});
    chk("pop_valid",  {63'h0, bus.pop_valid},  {63'h0, e_pv});
    chk("count",      {61'h0, bus.count},      64'(n));
    chk("IF_ID",      bus.IF_ID,               e_data);
    if (fl) begin
      sb.delete();
    end else if (!(byp && pr)) begin
      if (e_pv && pr && n != 0) void'(sb.pop_front());
      if (pv && e_pr) sb.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic pr);
    step(1'b0, 1'b0, 32'h0, 32'h0, pr);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_b           = 1'b0;
    bus.flush         = 1'b0;
    bus.push_valid    = 1'b0;
    bus.push_pc_plus4 = '0;
    bus.push_instr    = '0;
    bus.pop_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    idle(1'b0);

    // Asynchronous reset asserted mid-cycle with a stored entry
    step(1'b0, 1'b1, 32'h4, 32'h2008_0001, 1'b0);
    idle(1'b0);
    #2 reset_b = 1'b0;
    #1;
    chk("rst_IF_ID",      bus.IF_ID, 64'h0);
    chk("rst_pop_valid",  {63'h0, bus.pop_valid}, 64'h0);
    chk("rst_count",      {61'h0, bus.count}, 64'h0);
    chk("rst_push_ready", {63'h0, bus.push_ready}, 64'h1);
    sb.delete();
    @(posedge clk);
    #1 reset_b = 1'b1;
    idle(1'b0);

    // Fill to full, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 32'(4 * i), 32'h2008_0000 + 32'(i), 1'b0);
    idle(1'b0);
    chk("full_count", {61'h0, bus.count}, 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Streaming at count=1 across two pointer wraps
    step(1'b0, 1'b1, 32'h100, 32'hA000_0000, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
    chk("stream_count", {61'h0, bus.count}, 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Flush at count=3 with simultaneous push and pop
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Full with pop: only the pop happens, the held word enters next cycle
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0);
    step(1'b0, 1'b1, 32'h310, 32'hC000_0004, 1'b1);
    chk("fullpop_count", {61'h0, bus.count}, 64'd3);
    step(1'b0, 1'b1, 32'h310, 32'hC000_0004, 1'b0);
    chk("fullpop_refill", {61'h0, bus.count}, 64'd4);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Empty queue, push with pop_ready: bypass or one-cycle latency
    step(1'b0, 1'b1, 32'h4, 32'h8C09_0000, 1'b1);
    chk("byp_count", {61'h0, bus.count}, BYP ? 64'd0 : 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Mixed random traffic
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 15) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom));
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
